// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM states and
// next-PC source codes.
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_WIDTH = 26;
    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam logic [25:0] IFU_RESET_PC   = 26'h0001000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StDone = 2'b10
    } ifu_state_e;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
    localparam logic [1:0] PC_SEL_REG = 2'b11;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection: increment, PC-relative branch, absolute jump or register
// target. All arithmetic wraps modulo 2^ADDR_WIDTH.
module ifu_next_pc
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            pc_sel,
    input  logic [15:0]           branch_imm,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic [31:0]           reg_target,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] br_off;

    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign br_off = {{(ADDR_WIDTH-16){branch_imm[15]}}, branch_imm};

    // Only the low address bits of the register are meaningful for jr.
    logic unused_reg_hi;
    assign unused_reg_hi = ^reg_target[31:ADDR_WIDTH];

    always_comb begin
        next_pc = pc_inc;
        unique case (pc_sel)
            PC_SEL_INC: next_pc = pc_inc;
            PC_SEL_BR:  next_pc = pc_inc + br_off;
            PC_SEL_JMP: next_pc = jump_addr;
            PC_SEL_REG: next_pc = reg_target[ADDR_WIDTH-1:0];
            default:    next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/WAIT/DONE fetch FSM and instruction register.
// Define IFU_TIMEOUT_EN to abandon fetches that wait TIMEOUT_CYCLES edges without MEM_READY.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH     = IFU_ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH     = IFU_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC       = ADDR_WIDTH'(IFU_RESET_PC),
    parameter int unsigned            TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FETCH_REQ,
    input  logic                  PC_LOAD,
    input  logic [1:0]            PC_SEL,
    input  logic [15:0]           BRANCH_IMM,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
    input  logic [31:0]           REG_TARGET,
    input  logic                  MEM_READY,
    input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
    output logic                  MEM_READ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] INSTRUCTION,
    output logic                  INSTR_VALID,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  FETCH_BUSY,
    output logic                  FETCH_ERR
);

    ifu_state_e            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  busy_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] next_pc;

    ifu_next_pc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc        (pc_q),
        .pc_sel    (PC_SEL),
        .branch_imm(BRANCH_IMM),
        .jump_addr (JUMP_ADDR),
        .reg_target(REG_TARGET),
        .next_pc   (next_pc)
    );

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q;
    logic            err_q;
    assign FETCH_ERR = err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign FETCH_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            instr_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            err_q      <= 1'b0;
            tmo_cnt_q  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            // PC updates in every state; a fetch already issued keeps its latched address.
            if (PC_LOAD) begin
                pc_q <= next_pc;
            end
            unique case (state_q)
                StIdle: begin
                    if (FETCH_REQ) begin
                        mem_addr_q <= pc_q;
                        busy_q     <= 1'b1;
                        state_q    <= StWait;
`ifdef IFU_TIMEOUT_EN
                        tmo_cnt_q  <= '0;
`endif
                    end
                end
                StWait: begin
                    if (MEM_READY) begin
                        instr_q <= MEM_DATA_IN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
`ifdef IFU_TIMEOUT_EN
                    else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
`endif
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign MEM_READ    = busy_q;
    assign FETCH_BUSY  = busy_q;
    assign MEM_ADDR    = mem_addr_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver issues fetches and PC loads, a negedge monitor
// pops expected instructions whenever INSTR_VALID is seen.
module tb_instr_fetch_unit;

    localparam logic [25:0] RST_PC = 26'h0001000;
    localparam int unsigned TMO    = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FETCH_REQ = 1'b0;
    logic        PC_LOAD = 1'b0;
    logic [1:0]  PC_SEL = 2'b00;
    logic [15:0] BRANCH_IMM = '0;
    logic [25:0] JUMP_ADDR = '0;
    logic [31:0] REG_TARGET = '0;
    logic        MEM_READY = 1'b0;
    logic [31:0] MEM_DATA_IN = '0;
    logic        MEM_READ;
    logic [25:0] MEM_ADDR;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [25:0] PC;
    logic        FETCH_BUSY;
    logic        FETCH_ERR;

    instr_fetch_unit #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FETCH_REQ  (FETCH_REQ),
        .PC_LOAD    (PC_LOAD),
        .PC_SEL     (PC_SEL),
        .BRANCH_IMM (BRANCH_IMM),
        .JUMP_ADDR  (JUMP_ADDR),
        .REG_TARGET (REG_TARGET),
        .MEM_READY  (MEM_READY),
        .MEM_DATA_IN(MEM_DATA_IN),
        .MEM_READ   (MEM_READ),
        .MEM_ADDR   (MEM_ADDR),
        .INSTRUCTION(INSTRUCTION),
        .INSTR_VALID(INSTR_VALID),
        .PC         (PC),
        .FETCH_BUSY (FETCH_BUSY),
        .FETCH_ERR  (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [25:0] pc_m   = RST_PC;
    logic [31:0] inst_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule, plain integer arithmetic modulo 2^26.
    function automatic logic [25:0] ref_next(input logic [25:0] pc, input logic [1:0] sel,
                                             input logic [15:0] imm, input logic [25:0] j,
                                             input logic [31:0] r);
        longint t;
        case (sel)
            2'd0:    t = longint'(pc) + 1;
            2'd1:    t = longint'(pc) + 1 + longint'($signed(imm));
            2'd2:    t = longint'(j);
            default: t = longint'(r);
        endcase
        return t[25:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            pc_m   = RST_PC;
            inst_m = '0;
            exp_q.delete();
        end else if (PC_LOAD) begin
            pc_m = ref_next(pc_m, PC_SEL, BRANCH_IMM, JUMP_ADDR, REG_TARGET);
        end
        #1;
        PC_LOAD     = 1'b0;
        FETCH_REQ   = 1'b0;
        MEM_READY   = 1'b0;
        MEM_DATA_IN = $urandom;
    endtask

    task automatic rand_load();
        PC_LOAD    = 1'b1;
        PC_SEL     = 2'($urandom_range(3));
        BRANCH_IMM = 16'($urandom);
        JUMP_ADDR  = 26'($urandom);
        REG_TARGET = $urandom;
    endtask

    task automatic load_pc(input string name, input logic [1:0] sel, input logic [15:0] imm,
                           input logic [25:0] j, input logic [31:0] r, input logic [25:0] exp);
        PC_LOAD = 1'b1; PC_SEL = sel; BRANCH_IMM = imm; JUMP_ADDR = j; REG_TARGET = r;
        tick();
        @(negedge CLK);
        chk(name, 64'(PC), 64'(exp));
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_pc"}, 64'(PC), 64'(RST_PC));
        chk({name, "_addr"}, 64'(MEM_ADDR), 64'(RST_PC));
        chk({name, "_ir"}, 64'(INSTRUCTION), 64'h0);
        chk({name, "_flags"}, 64'({MEM_READ, FETCH_BUSY, INSTR_VALID, FETCH_ERR}), 64'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check_reset_state("reset");
    endtask

    task automatic fetch(input int waits, input logic [31:0] data, input bit req_noise,
                         input bit load_noise);
        exp_t e;
        e.addr = pc_m;
        e.data = data;
        exp_q.push_back(e);
        FETCH_REQ = 1'b1;
        if (load_noise) rand_load();
        tick();
        for (int i = 0; i < waits; i++) begin
            FETCH_REQ = req_noise;
            if (load_noise && $urandom_range(1) == 1) rand_load();
            @(negedge CLK);
            chk("busy_wait", 64'({MEM_READ, FETCH_BUSY}), 64'h3);
            chk("addr_hold", 64'(MEM_ADDR), 64'(e.addr));
            chk("ir_hold", 64'(INSTRUCTION), 64'(inst_m));
            chk("pc_wait", 64'(PC), 64'(pc_m));
            chk("err_quiet", 64'(FETCH_ERR), 64'h0);
            tick();
        end
        MEM_READY   = 1'b1;
        MEM_DATA_IN = data;
        @(negedge CLK);
        chk("busy_ready", 64'({MEM_READ, FETCH_BUSY}), 64'h3);
        tick();
        FETCH_REQ = req_noise;
        @(negedge CLK);
        chk("valid_pulse", 64'(INSTR_VALID), 64'h1);
        chk("busy_done", 64'({MEM_READ, FETCH_BUSY}), 64'h0);
        chk("pc_done", 64'(PC), 64'(pc_m));
        tick();
        @(negedge CLK);
        chk("idle_after", 64'({MEM_READ, FETCH_BUSY, INSTR_VALID}), 64'h0);
    endtask

    // Monitor: every INSTR_VALID must match the oldest outstanding fetch.
    always @(negedge CLK) begin
        if (INSTR_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 64'(INSTR_VALID), 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("instr", 64'(INSTRUCTION), 64'(mon_e.data));
                chk("fetch_addr", 64'(MEM_ADDR), 64'(mon_e.addr));
                inst_m = mon_e.data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        tick();
        do_reset();

        // Zero-wait fetch straight after reset.
        fetch(0, 32'h2002_0005, 1'b0, 1'b0);
        chk("first_addr", 64'(MEM_ADDR), 64'(26'h0001000));
        chk("first_instr", 64'(INSTRUCTION), 64'h2002_0005);

        // Three wait states with FETCH_REQ held during WAIT/DONE.
        fetch(3, 32'hA5A5_0F0F, 1'b1, 1'b0);
        chk("wait3_instr", 64'(INSTRUCTION), 64'hA5A5_0F0F);

        // Next-PC sources and wrap.
        load_pc("jmp_setup", 2'b10, 16'h0, 26'h0001010, 32'h0, 26'h0001010);
        load_pc("branch_neg", 2'b01, 16'hFFFE, 26'h0, 32'h0, 26'h000100F);
        load_pc("jump", 2'b10, 16'h0, 26'h0000040, 32'h0, 26'h0000040);
        load_pc("jr", 2'b11, 16'h0, 26'h0, 32'hFC00_0123, 26'h0000123);
        load_pc("jmp_top", 2'b10, 16'h0, 26'h3FFFFFF, 32'h0, 26'h3FFFFFF);
        load_pc("inc_wrap", 2'b00, 16'h0, 26'h0, 32'h0, 26'h0000000);
        load_pc("branch_pos", 2'b01, 16'h7FFF, 26'h0, 32'h0, 26'h0008000);

        // Fetch and PC load in the same IDLE cycle: fetch uses the old PC.
        PC_SEL = 2'b10; JUMP_ADDR = 26'h0002222; PC_LOAD = 1'b1;
        fetch(1, 32'h1234_5678, 1'b0, 1'b0);
        chk("same_cycle_pc", 64'(PC), 64'(26'h0002222));
        chk("same_cycle_addr", 64'(MEM_ADDR), 64'(26'h0008000));

        // Reset in WAIT, then a late MEM_READY must be ignored.
        FETCH_REQ = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst_wait_busy", 64'({MEM_READ, FETCH_BUSY}), 64'h3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        MEM_READY   = 1'b1;
        MEM_DATA_IN = 32'hDEAD_BEEF;
        @(negedge CLK);
        check_reset_state("rst_wait");
        tick();
        @(negedge CLK);
        check_reset_state("rst_late_ready");

`ifdef IFU_TIMEOUT_EN
        fetch(0, 32'h0BAD_F00D, 1'b0, 1'b0);
        FETCH_REQ = 1'b1;
        tick();
        for (int i = 0; i < int'(TMO); i++) begin
            @(negedge CLK);
            chk("tmo_busy", 64'({MEM_READ, FETCH_BUSY, FETCH_ERR}), 64'h6);
            tick();
        end
        @(negedge CLK);
        chk("tmo_err", 64'({MEM_READ, FETCH_BUSY, FETCH_ERR, INSTR_VALID}), 64'h2);
        chk("tmo_ir", 64'(INSTRUCTION), 64'h0BAD_F00D);
        tick();
        @(negedge CLK);
        chk("tmo_err_pulse", 64'(FETCH_ERR), 64'h0);
        fetch(2, 32'hC0DE_0001, 1'b0, 1'b0);
`else
        fetch(20, 32'h0BAD_F00D, 1'b0, 1'b0);
        chk("long_wait_ir", 64'(INSTRUCTION), 64'h0BAD_F00D);
`endif

        // Randomized mix of fetches and PC loads against the model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0) begin
                rand_load();
                tick();
                @(negedge CLK);
                chk("rand_pc", 64'(PC), 64'(pc_m));
            end else begin
                fetch(int'($urandom_range(5)), $urandom, 1'($urandom_range(1)),
                      1'($urandom_range(1)));
            end
        end

        tick();
        tick();
        @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
